// File: rtl/sram_if_bram_responder_if.sv
// sram_if_bram_responder_if: SRAM-like wrap_* bus between initiator (master) and responder (slave)
interface sram_if_bram_responder_if;
  logic [31:0] wrap_Addr;
  logic        wrap_CS;
  logic        wrap_L;
  logic        wrap_U;
  logic        wrap_WE;
  logic [15:0] wrap_WR;
  logic [15:0] wrap_RD;
  logic        wrap_ready;
  logic        wrap_busy;
  modport master (
    output wrap_Addr, wrap_CS, wrap_L, wrap_U, wrap_WE, wrap_WR,
    input  wrap_RD, wrap_ready, wrap_busy
  );
  modport slave (
    input  wrap_Addr, wrap_CS, wrap_L, wrap_U, wrap_WE, wrap_WR,
    output wrap_RD, wrap_ready, wrap_busy
  );
endinterface

// File: rtl/sram_if_bram_responder.sv
// sram_if_bram_responder: BRAM-backed wrap_* responder with programmable busy latency; SRAM_RESP_RANGE_CHK_EN adds o_range_err
module sram_if_bram_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 3
) (
  input logic clk,
  input logic i_rst,
  sram_if_bram_responder_if.slave wrap
`ifdef SRAM_RESP_RANGE_CHK_EN
  ,
  output logic o_range_err
`endif
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [7:0] cnt;
  logic [ADDR_W-1:0] addr_q;
  logic l_q, u_q, we_q;
  logic [15:0] wr_q, rd_q;
  logic [15:0] mem [0:(1<<ADDR_W)-1];
  logic fin, oor, accept;
  assign accept = state == IDLE && wrap.wrap_CS;
  assign fin = state == BUSY && cnt == 8'(LATENCY - 1);
  assign wrap.wrap_RD = rd_q;
`ifdef SRAM_RESP_RANGE_CHK_EN
  logic oor_q;
  assign oor = oor_q;
  // remember whether the accepted address had any upper bit set
  always_ff @(posedge clk)
    if (i_rst) oor_q <= 1'b0;
    else if (accept) oor_q <= |wrap.wrap_Addr[31:ADDR_W];
`else
  logic unused_hi;
  assign unused_hi = ^wrap.wrap_Addr[31:ADDR_W];
  assign oor = 1'b0;
`endif
  // state register
  always_ff @(posedge clk)
    state <= i_rst ? IDLE : state_n;
  // next state: accept in IDLE, count out the busy window, one DONE cycle
  always_comb
    state_n = state == IDLE ? (wrap.wrap_CS ? BUSY : IDLE) :
              state == BUSY ? (fin ? DONE : BUSY) : IDLE;
  // handshake outputs decoded from state
  always_comb begin
    wrap.wrap_busy  = state == BUSY;
    wrap.wrap_ready = state == DONE;
  end
  // request latch, latency counter and read data; reset drops any pending request
  always_ff @(posedge clk)
    if (i_rst) begin
      cnt  <= 8'd0;
      rd_q <= 16'h0000;
`ifdef SRAM_RESP_RANGE_CHK_EN
      o_range_err <= 1'b0;
`endif
    end else begin
      cnt <= state == BUSY ? cnt + 8'd1 : 8'd0;
      if (accept) begin
        addr_q <= wrap.wrap_Addr[ADDR_W-1:0];
        l_q    <= wrap.wrap_L;
        u_q    <= wrap.wrap_U;
        we_q   <= wrap.wrap_WE;
        wr_q   <= wrap.wrap_WR;
      end
      if (fin && !we_q)
        rd_q <= oor ? 16'hDEAD : {u_q ? mem[addr_q][15:8] : 8'h00, l_q ? mem[addr_q][7:0] : 8'h00};
`ifdef SRAM_RESP_RANGE_CHK_EN
      if (fin && oor) o_range_err <= 1'b1;
`endif
    end
  // byte-lane write committed on the edge that enters DONE; contents survive reset
  always_ff @(posedge clk)
    if (!i_rst && fin && we_q && !oor) begin
      if (l_q) mem[addr_q][7:0] <= wr_q[7:0];
      if (u_q) mem[addr_q][15:8] <= wr_q[15:8];
    end
endmodule

// File: tb/tb_sram_if_bram_responder.sv
// tb_sram_if_bram_responder: directed vectors, multi-cycle corner sequences and model-checked random traffic
module tb_sram_if_bram_responder;
  logic clk = 1'b0;
  logic i_rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  sram_if_bram_responder_if w();
`ifdef SRAM_RESP_RANGE_CHK_EN
  logic o_range_err;
  sram_if_bram_responder #(.ADDR_W(10), .LATENCY(3)) dut (.clk(clk), .i_rst(i_rst), .wrap(w.slave), .o_range_err(o_range_err));
`else
  sram_if_bram_responder #(.ADDR_W(10), .LATENCY(3)) dut (.clk(clk), .i_rst(i_rst), .wrap(w.slave));
`endif
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    logic        we;
    logic [31:0] a;
    logic        l;
    logic        u;
    logic [15:0] wd;
    logic [15:0] exp;
  } vec_t;
  vec_t tv[12];
  logic [15:0] model [16];
  logic [15:0] last_rd;
  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endfunction
  task automatic xact(input logic we, input logic [31:0] a, input logic l, input logic u, input logic [15:0] wd,
                      output logic [15:0] rd, output int bc, output logic ok, output logic ov);
    @(negedge clk);
    w.wrap_CS = 1'b1; w.wrap_WE = we; w.wrap_Addr = a; w.wrap_L = l; w.wrap_U = u; w.wrap_WR = wd;
    @(negedge clk);
    w.wrap_CS = 1'b0; w.wrap_WE = ~we; w.wrap_Addr = $urandom; w.wrap_L = ~l; w.wrap_U = ~u; w.wrap_WR = ~wd;
    bc = 0; ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (w.wrap_ready) begin
        ok = 1'b1;
        break;
      end
      bc += int'(w.wrap_busy);
      @(negedge clk);
    end
    rd = w.wrap_RD;
    ov = w.wrap_busy;
  endtask
  task automatic run(input string n, input logic we, input logic [31:0] a, input logic l, input logic u,
                     input logic [15:0] wd, input logic [15:0] exp);
    logic [15:0] rd;
    int bc;
    logic ok, ov;
    xact(we, a, l, u, wd, rd, bc, ok, ov);
    chk({n, "_ready_seen"}, 32'(ok), 32'd1);
    chk({n, "_busy_cycles"}, bc, 32'd3);
    chk({n, "_busy_at_ready"}, 32'(ov), 32'd0);
    chk({n, "_rd"}, 32'(rd), 32'(exp));
  endtask
  initial begin
    int t[3];
    int nr, extra, idle;
    logic we, l, u;
    logic [3:0] idx;
    logic [15:0] wd, exp;
    tv[0]  = '{1'b1, 32'h032, 1'b1, 1'b1, 16'h0032, 16'h0000};
    tv[1]  = '{1'b0, 32'h032, 1'b1, 1'b1, 16'h0000, 16'h0032};
    tv[2]  = '{1'b1, 32'h005, 1'b1, 1'b1, 16'hFFFF, 16'h0032};
    tv[3]  = '{1'b1, 32'h005, 1'b1, 1'b0, 16'h1234, 16'h0032};
    tv[4]  = '{1'b0, 32'h005, 1'b1, 1'b1, 16'h0000, 16'hFF34};
    tv[5]  = '{1'b0, 32'h005, 1'b0, 1'b1, 16'h0000, 16'hFF00};
    tv[6]  = '{1'b0, 32'h005, 1'b1, 1'b0, 16'h0000, 16'h0034};
    tv[7]  = '{1'b1, 32'h006, 1'b0, 1'b0, 16'hABCD, 16'h0034};
    tv[8]  = '{1'b0, 32'h006, 1'b1, 1'b1, 16'h0000, 16'h0000};
    tv[9]  = '{1'b1, 32'h3FF, 1'b1, 1'b1, 16'h5A5A, 16'h0000};
    tv[10] = '{1'b0, 32'h3FF, 1'b1, 1'b1, 16'h0000, 16'h5A5A};
    tv[11] = '{1'b0, 32'h005, 1'b0, 1'b0, 16'h0000, 16'h0000};
    w.wrap_CS = 1'b0; w.wrap_WE = 1'b0; w.wrap_Addr = 32'h0; w.wrap_L = 1'b0; w.wrap_U = 1'b0; w.wrap_WR = 16'h0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(w.wrap_busy), 32'd0);
    chk("reset_ready", 32'(w.wrap_ready), 32'd0);
    chk("reset_rd", 32'(w.wrap_RD), 32'h0);
`ifdef SRAM_RESP_RANGE_CHK_EN
    chk("reset_range_err", 32'(o_range_err), 32'd0);
`endif
    i_rst = 1'b0;
    for (int i = 0; i < 12; i++)
      run($sformatf("vec%0d", i), tv[i].we, tv[i].a, tv[i].l, tv[i].u, tv[i].wd, tv[i].exp);
    // CS held high across three requests; bus garbage during busy must be ignored
    @(negedge clk);
    w.wrap_CS = 1'b1; w.wrap_WE = 1'b1; w.wrap_Addr = 32'h100; w.wrap_L = 1'b1; w.wrap_U = 1'b1; w.wrap_WR = 16'h1111;
    nr = 0;
    for (int k = 0; k < 100 && nr < 3; k++) begin
      @(negedge clk);
      if (w.wrap_ready) begin
        t[nr] = cyc;
        if (nr == 2) chk("b2b_rd", 32'(w.wrap_RD), 32'h1111);
        nr++;
        if (nr == 1) begin w.wrap_WE = 1'b1; w.wrap_Addr = 32'h101; w.wrap_L = 1'b1; w.wrap_U = 1'b1; w.wrap_WR = 16'h2222; end
        if (nr == 2) begin w.wrap_WE = 1'b0; w.wrap_Addr = 32'h100; w.wrap_L = 1'b1; w.wrap_U = 1'b1; w.wrap_WR = 16'h0; end
        if (nr == 3) w.wrap_CS = 1'b0;
      end else if (w.wrap_busy) begin
        w.wrap_WE = 1'($urandom); w.wrap_Addr = 32'($urandom_range(0, 1023)); w.wrap_WR = 16'($urandom);
        w.wrap_L = 1'($urandom); w.wrap_U = 1'($urandom);
      end
    end
    w.wrap_CS = 1'b0;
    chk("b2b_ready_count", nr, 32'd3);
    if (nr == 3) begin
      chk("b2b_gap01", t[1] - t[0], 32'd5);
      chk("b2b_gap12", t[2] - t[1], 32'd5);
    end
    extra = 0;
    repeat (8) begin @(negedge clk); extra += int'(w.wrap_ready); end
    chk("b2b_no_extra_ready", extra, 32'd0);
    run("b2b_rd101", 1'b0, 32'h101, 1'b1, 1'b1, 16'h0, 16'h2222);
    // reset in the second busy cycle of a write
    @(negedge clk);
    w.wrap_CS = 1'b1; w.wrap_WE = 1'b1; w.wrap_Addr = 32'h010; w.wrap_L = 1'b1; w.wrap_U = 1'b1; w.wrap_WR = 16'hAAAA;
    @(negedge clk);
    w.wrap_CS = 1'b0;
    @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    chk("rstmid_busy", 32'(w.wrap_busy), 32'd0);
    chk("rstmid_ready", 32'(w.wrap_ready), 32'd0);
    chk("rstmid_rd", 32'(w.wrap_RD), 32'h0);
    extra = 0;
    repeat (6) begin @(negedge clk); extra += int'(w.wrap_ready) + int'(w.wrap_busy); end
    chk("rstmid_quiet", extra, 32'd0);
    run("rstmid_rd010", 1'b0, 32'h010, 1'b1, 1'b1, 16'h0, 16'h0000);
    // reset and CS in the same cycle: request dropped
    @(negedge clk);
    i_rst = 1'b1;
    w.wrap_CS = 1'b1; w.wrap_WE = 1'b1; w.wrap_Addr = 32'h011; w.wrap_L = 1'b1; w.wrap_U = 1'b1; w.wrap_WR = 16'h7777;
    @(negedge clk);
    i_rst = 1'b0;
    w.wrap_CS = 1'b0;
    extra = 0;
    repeat (6) begin extra += int'(w.wrap_ready) + int'(w.wrap_busy); @(negedge clk); end
    chk("rstcs_quiet", extra, 32'd0);
    run("rstcs_rd011", 1'b0, 32'h011, 1'b1, 1'b1, 16'h0, 16'h0000);
    // random traffic in an untouched region against a byte-lane model
    for (int i = 0; i < 16; i++) model[i] = 16'h0;
    run("rnd_init", 1'b0, 32'h200, 1'b1, 1'b1, 16'h0, 16'h0000);
    last_rd = 16'h0;
    for (int i = 0; i < 3000; i++) begin
      idle = $urandom_range(0, 2);
      repeat (idle) @(negedge clk);
      we = 1'($urandom); idx = 4'($urandom); l = 1'($urandom); u = 1'($urandom); wd = 16'($urandom);
      exp = we ? last_rd : {u ? model[idx][15:8] : 8'h00, l ? model[idx][7:0] : 8'h00};
      run($sformatf("rnd%0d", i), we, 32'h200 + 32'(idx), l, u, wd, exp);
      if (we) begin
        if (l) model[idx][7:0] = wd[7:0];
        if (u) model[idx][15:8] = wd[15:8];
      end else last_rd = exp;
    end
    // upper address bits: aliasing or range error depending on build
`ifdef SRAM_RESP_RANGE_CHK_EN
    chk("range_err_before", 32'(o_range_err), 32'd0);
    run("oor_wr400", 1'b1, 32'h400, 1'b1, 1'b1, 16'hBEEF, last_rd);
    chk("range_err_after", 32'(o_range_err), 32'd1);
    run("oor_rd400", 1'b0, 32'h400, 1'b1, 1'b1, 16'h0, 16'hDEAD);
    run("oor_rd000", 1'b0, 32'h000, 1'b1, 1'b1, 16'h0, 16'h0000);
`else
    run("alias_wr400", 1'b1, 32'h400, 1'b1, 1'b1, 16'hBEEF, last_rd);
    run("alias_rd000", 1'b0, 32'h000, 1'b1, 1'b1, 16'h0, 16'hBEEF);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
